// File: rtl/vga_pkg.sv
// Shared VGA pixel-path types: default resolution, coordinate widths, 12-bit RGB colour.
// Pure declarations; no timing or flow control of its own.
package vga_pkg;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    localparam int COORD_W   = 10;
    // One extra bit so position+size+speed sums never wrap during compares.
    localparam int CALC_W    = COORD_W + 1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CALC_W-1:0]  calc_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    localparam rgb12_t RGB_BLACK = '0;

    function automatic rgb12_t rgb12(input logic [11:0] hex);
        return rgb12_t'(hex);
    endfunction

    function automatic logic [3:0] rgb_r(input rgb12_t c);
        return c.r;
    endfunction

    function automatic logic [3:0] rgb_g(input rgb12_t c);
        return c.g;
    endfunction

    function automatic logic [3:0] rgb_b(input rgb12_t c);
        return c.b;
    endfunction

endpackage

// File: rtl/vga_axis_bouncer.sv
// One axis of the bouncing square: position and direction, stepped once per enabled frame.
// New position and flip pulse are registered, 1 clk after step; no backpressure.
module vga_axis_bouncer
    import vga_pkg::*;
#(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int SPEED = 2,
    parameter int INIT  = 304
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step,
    output coord_t pos,
    output logic   flip
);

    localparam calc_t LIMIT_C = calc_t'(LIMIT);
    localparam calc_t SIZE_C  = calc_t'(SIZE);
    localparam calc_t SPEED_C = calc_t'(SPEED);
    localparam coord_t WALL_HI = coord_t'(LIMIT - SIZE);
    localparam coord_t INIT_C  = coord_t'(INIT);

    dir_t  dir;
    calc_t pos_ext;
    logic  past_high;
    logic  past_low;

    assign pos_ext   = {1'b0, pos};
    assign past_high = (pos_ext + SIZE_C + SPEED_C) > LIMIT_C;
    assign past_low  = pos_ext < SPEED_C;

    // A step that would overshoot a wall lands exactly on it and reverses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= INIT_C;
            dir  <= DIR_INC;
            flip <= 1'b0;
        end else begin
            flip <= 1'b0;
            if (step) begin
                case (dir)
                    DIR_INC: begin
                        if (past_high) begin
                            pos  <= WALL_HI;
                            dir  <= DIR_DEC;
                            flip <= 1'b1;
                        end else begin
                            pos <= pos + coord_t'(SPEED);
                        end
                    end
                    DIR_DEC: begin
                        if (past_low) begin
                            pos  <= '0;
                            dir  <= DIR_INC;
                            flip <= 1'b1;
                        end else begin
                            pos <= pos - coord_t'(SPEED);
                        end
                    end
                    default: begin
                        dir <= DIR_INC;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_bounce_square.sv
// Draws a solid square over a background, moving it once per frame and reflecting off the edges.
// Paint is registered 1 clk after sx/sy/de; position and bounce 1 clk after frame_start; no backpressure.
module vga_bounce_square
    import vga_pkg::*;
#(
    parameter int          H_RES    = DEF_H_RES,
    parameter int          V_RES    = DEF_V_RES,
    parameter int          SIZE     = 32,
    parameter int          SPEED    = 2,
    parameter int          INIT_X   = 304,
    parameter int          INIT_Y   = 224,
    parameter logic [11:0] SQ_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h137
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [9:0]   sx,
    input  logic [9:0]   sy,
    input  logic         de,
    input  logic         frame_start,
    input  logic         enable,
    output logic [3:0]   paint_r,
    output logic [3:0]   paint_g,
    output logic [3:0]   paint_b,
    output logic [9:0]   pos_x,
    output logic [9:0]   pos_y,
    output logic         bounce
);

    localparam rgb12_t SQ_RGB  = rgb12(SQ_COLOR);
    localparam rgb12_t BG_RGB  = rgb12(BG_COLOR);
    localparam calc_t  SPAN_C  = calc_t'(SIZE - 1);

    logic   step;
    logic   flip_x;
    logic   flip_y;
    calc_t  sx_ext;
    calc_t  sy_ext;
    calc_t  x_lo;
    calc_t  x_hi;
    calc_t  y_lo;
    calc_t  y_hi;
    logic   in_x;
    logic   in_y;
    rgb12_t paint;

    assign step = frame_start & enable;

    vga_axis_bouncer #(
        .LIMIT (H_RES),
        .SIZE  (SIZE),
        .SPEED (SPEED),
        .INIT  (INIT_X)
    ) u_axis_x (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .pos   (pos_x),
        .flip  (flip_x)
    );

    vga_axis_bouncer #(
        .LIMIT (V_RES),
        .SIZE  (SIZE),
        .SPEED (SPEED),
        .INIT  (INIT_Y)
    ) u_axis_y (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .pos   (pos_y),
        .flip  (flip_y)
    );

    // A corner hit flips both axes in the same cycle, which still reads as one pulse.
    assign bounce = flip_x | flip_y;

    assign sx_ext = {1'b0, sx};
    assign sy_ext = {1'b0, sy};
    assign x_lo   = {1'b0, pos_x};
    assign y_lo   = {1'b0, pos_y};
    assign x_hi   = x_lo + SPAN_C;
    assign y_hi   = y_lo + SPAN_C;
    assign in_x   = (sx_ext >= x_lo) && (sx_ext <= x_hi);
    assign in_y   = (sy_ext >= y_lo) && (sy_ext <= y_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paint <= RGB_BLACK;
        end else if (!de) begin
            paint <= RGB_BLACK;
        end else if (in_x && in_y) begin
            paint <= SQ_RGB;
        end else begin
            paint <= BG_RGB;
        end
    end

    assign paint_r = rgb_r(paint);
    assign paint_g = rgb_g(paint);
    assign paint_b = rgb_b(paint);

endmodule

// File: doc/vga_bounce_square.md
# vga_bounce_square

Moving-square renderer for the VGA pixel path: draws a solid square of parametrised size and colour over a background and advances its position once per frame, reflecting off the screen edges. It replaces the fixed centred square, sits between the sync/coordinate generator (sx, sy, de, frame_start) and the DAC output registers, and drives registered 4-bit-per-channel colour.

## Interface
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- SIZE, 32: square side length in pixels, 1..min(H_RES,V_RES)-SPEED.
- SPEED, 2: pixels moved per axis per frame, 1..15.
- INIT_X, 304: reset x of the top-left corner; must satisfy INIT_X <= H_RES-SIZE.
- INIT_Y, 224: reset y of the top-left corner; must satisfy INIT_Y <= V_RES-SIZE.
- SQ_COLOR, 12'hFFF: square colour, RGB hex triplet.
- BG_COLOR, 12'h137: background colour, RGB hex triplet.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- sx  in  10  current pixel column.
- sy  in  10  current pixel row.
- de  in  1  display enable, high in the visible area.
- frame_start  in  1  single-cycle pulse, once per frame, during vertical blanking.
- enable  in  1  motion enable; 0 freezes position, drawing continues.
- paint_r / paint_g / paint_b  out  4 each  registered colour.
- pos_x  out  10  current top-left x.
- pos_y  out  10  current top-left y.
- bounce  out  1  one-cycle pulse when a reflection occurs.

## Operation
- Per-axis state: position register plus direction bit (0 = increasing, 1 = decreasing). Combined direction state: SE (reset), SW, NE, NW.
- Hit test: square = (pos_x <= sx <= pos_x+SIZE-1) and (pos_y <= sy <= pos_y+SIZE-1), inclusive on all edges. Compare at 11 bits; no wrap.
- Colour: de=0 -> 0x000; de=1 and square -> SQ_COLOR; de=1 otherwise -> BG_COLOR.
- Update on frame_start=1 and enable=1, each axis independently (x shown; y identical with V_RES):
  - increasing: if pos_x+SIZE+SPEED > H_RES then pos_x <= H_RES-SIZE, dir flips; else pos_x <= pos_x+SPEED.
  - decreasing: if pos_x < SPEED then pos_x <= 0, dir flips; else pos_x <= pos_x-SPEED.
- Square therefore never leaves the visible area and lands exactly on the wall when it flips.
- bounce = 1 on the cycle after any update where at least one axis flipped; a corner hit (both axes flip) yields one pulse.
- frame_start with enable=0: no change, no bounce.

## Timing
- Reset (async assert, sync release): pos_x=INIT_X, pos_y=INIT_Y, direction SE, paint_*=0, bounce=0.
- Paint latency: 1 clk from sx/sy/de to paint_*.
- Position/direction update visible on pos_x/pos_y and in hit test 1 clk after the frame_start cycle; a pixel sampled in the frame_start cycle uses the old position.
- bounce asserted in the same cycle the new position appears.
- frame_start on consecutive cycles: each pulse is a separate update.
- Reset mid-frame: outputs return to reset values immediately; motion restarts from INIT on the next enabled frame_start.

## Structure
- Shared package vga_pkg: H_RES/V_RES defaults, coordinate width (10), rgb12_t typedef with r/g/b field accessors.
- Sub-module vga_axis_bouncer (params LIMIT, SIZE, SPEED, INIT): position + direction register, flip pulse; instantiated once for x, once for y. Top ORs flips into bounce and holds the hit test and colour register.

## Test plan
- Reset with defaults -> pos=(304,224), paint=0, bounce=0; sx=304,sy=224,de=1 -> next clk paint=FFF; sx=303 -> 137.
- de=0 at sx=310,sy=230 -> paint=000 one clk later.
- INIT_X=605, SIZE=32, SPEED=2: frame_start -> pos_x=607, no bounce; next frame_start -> pos_x=608, dir flips, bounce pulse; next -> 606.
- INIT_X=1, INIT_Y=1 with direction forced to NW by bouncing: verify x and y reach 0 on the same frame -> single bounce pulse, next frame pos=(2,2).
- enable=0 for 10 frame_starts -> pos unchanged, no bounce; re-enable -> motion resumes from held position.
- Assert rst_n low mid-frame after 50 frames -> pos, direction, paint, bounce return to reset values asynchronously.
